// File: rtl/pilha_ctrl.sv
// pilha_ctrl -- operand stack controller for the processor datapath.
//
// Owns the stack storage and stack pointer, executes single-cycle push/pop
// strobes from the control unit and presents a registered top-of-stack.
// Each accepted request runs OCIOSO -> EXEC -> CONCLUI; feito, the new topo
// and any error flag appear together two clocks after the strobe is sampled.
//
// Optional build macro: PILHA_SEGUNDO_EN adds the registered 'segundo' output
// (entry below the top, 0 when fewer than two entries).
//
// Ports:
//   clock      system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   push/pop   request strobes, sampled only while idle (both = replace top)
//   sel_ula    push source select: 0 = data_uc, 1 = data_ula
//   data_uc    push data from control unit
//   data_ula   push data from ALU result
//   limpa      clear stack, highest priority in any state
//   topo       registered top-of-stack, 0 when empty
//   segundo    (PILHA_SEGUNDO_EN only) registered second entry
//   sp         current entry count, 0..DEPTH
//   vazia      sp == 0
//   cheia      sp == DEPTH
//   ocupado    operation in flight
//   feito      one-cycle completion pulse
//   erro_over  sticky: push attempted while full
//   erro_under sticky: pop (or replace) attempted while empty

module pilha_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             sel_ula,
    input  logic [WIDTH-1:0] data_uc,
    input  logic [WIDTH-1:0] data_ula,
    input  logic             limpa,
    output logic [WIDTH-1:0] topo,
`ifdef PILHA_SEGUNDO_EN
    output logic [WIDTH-1:0] segundo,
`endif
    output logic [SPW-1:0]   sp,
    output logic             vazia,
    output logic             cheia,
    output logic             ocupado,
    output logic             feito,
    output logic             erro_over,
    output logic             erro_under
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OCIOSO,
        EXEC,
        CONCLUI
    } estado_t;

    estado_t          estado;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] operand;
    logic             op_push;
    logic             op_pop;
    logic             pend_over;
    logic             pend_under;
    logic [AW-1:0]    idx_topo;
`ifdef PILHA_SEGUNDO_EN
    logic [AW-1:0]    idx_seg;
`endif

    assign vazia    = (sp == '0);
    assign cheia    = (sp == SPW'(DEPTH));
    assign idx_topo = AW'(sp - SPW'(1));
`ifdef PILHA_SEGUNDO_EN
    assign idx_seg  = AW'(sp - SPW'(2));
`endif

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            // limpa shares the reset path: any in-flight op is discarded
            // before it reaches EXEC's write, and a same-cycle strobe is lost.
            estado     <= OCIOSO;
            sp         <= '0;
            topo       <= '0;
`ifdef PILHA_SEGUNDO_EN
            segundo    <= '0;
`endif
            ocupado    <= 1'b0;
            feito      <= 1'b0;
            erro_over  <= 1'b0;
            erro_under <= 1'b0;
            op_push    <= 1'b0;
            op_pop     <= 1'b0;
            pend_over  <= 1'b0;
            pend_under <= 1'b0;
            operand    <= '0;
        end else begin
            feito <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (push || pop) begin
                        op_push <= push;
                        op_pop  <= pop;
                        operand <= sel_ula ? data_ula : data_uc;
                        ocupado <= 1'b1;
                        estado  <= EXEC;
                    end
                end

                EXEC: begin
                    // Errors are held here and published in CONCLUI so they
                    // rise together with feito.
                    pend_over  <= 1'b0;
                    pend_under <= 1'b0;
                    if (op_push && !op_pop) begin
                        if (!cheia) begin
                            mem[sp[AW-1:0]] <= operand;
                            sp              <= sp + SPW'(1);
                        end else begin
                            pend_over <= 1'b1;
                        end
                    end else if (op_pop && !op_push) begin
                        if (!vazia) begin
                            sp <= sp - SPW'(1);
                        end else begin
                            pend_under <= 1'b1;
                        end
                    end else begin
                        if (!vazia) begin
                            mem[idx_topo] <= operand;
                        end else begin
                            pend_under <= 1'b1;
                        end
                    end
                    estado <= CONCLUI;
                end

                CONCLUI: begin
                    topo       <= vazia ? '0 : mem[idx_topo];
`ifdef PILHA_SEGUNDO_EN
                    segundo    <= (sp < SPW'(2)) ? '0 : mem[idx_seg];
`endif
                    erro_over  <= erro_over  | pend_over;
                    erro_under <= erro_under | pend_under;
                    feito      <= 1'b1;
                    ocupado    <= 1'b0;
                    estado     <= OCIOSO;
                end

                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pilha_ctrl.sv
module tb_pilha_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic             sel_ula;
    logic [WIDTH-1:0] data_uc;
    logic [WIDTH-1:0] data_ula;
    logic             limpa;
    logic [WIDTH-1:0] topo;
`ifdef PILHA_SEGUNDO_EN
    logic [WIDTH-1:0] segundo;
`endif
    logic [SPW-1:0]   sp;
    logic             vazia;
    logic             cheia;
    logic             ocupado;
    logic             feito;
    logic             erro_over;
    logic             erro_under;

    int checks = 0;
    int errors = 0;

    pilha_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .sel_ula   (sel_ula),
        .data_uc   (data_uc),
        .data_ula  (data_ula),
        .limpa     (limpa),
        .topo      (topo),
`ifdef PILHA_SEGUNDO_EN
        .segundo   (segundo),
`endif
        .sp        (sp),
        .vazia     (vazia),
        .cheia     (cheia),
        .ocupado   (ocupado),
        .feito     (feito),
        .erro_over (erro_over),
        .erro_under(erro_under)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request through the full handshake, checking the pulse timing.
    task automatic op(input string tag, input logic p, input logic q, input logic s,
                      input logic [15:0] uc, input logic [15:0] ula);
        push = p; pop = q; sel_ula = s; data_uc = uc; data_ula = ula;
        tick();
        push = 1'b0; pop = 1'b0;
        chk({tag, ".ocupado1"}, ocupado, 1);
        chk({tag, ".feito1"}, feito, 0);
        tick();
        chk({tag, ".ocupado2"}, ocupado, 1);
        chk({tag, ".feito2"}, feito, 0);
        tick();
        chk({tag, ".feito3"}, feito, 1);
        chk({tag, ".ocupado3"}, ocupado, 0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; sel_ula = 1'b0;
        data_uc = '0; data_ula = '0; limpa = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst.sp", sp, 0);
        chk("rst.topo", topo, 0);
        chk("rst.vazia", vazia, 1);
        chk("rst.cheia", cheia, 0);
        chk("rst.ocupado", ocupado, 0);
        chk("rst.feito", feito, 0);
        chk("rst.erro_over", erro_over, 0);
        chk("rst.erro_under", erro_under, 0);
`ifdef PILHA_SEGUNDO_EN
        chk("rst.segundo", segundo, 0);
`endif

        // First push from data_uc
        op("push5", 1, 0, 0, 16'h0005, 16'h0BAD);
        chk("push5.topo", topo, 16'h0005);
        chk("push5.sp", sp, 1);
        chk("push5.vazia", vazia, 0);
        tick();
        chk("push5.feito_drop", feito, 0);
        // first entry replaced below; restart with 1..4
        limpa = 1'b1; tick(); limpa = 1'b0;
        chk("limpa0.sp", sp, 0);

        // Fill to DEPTH, then overflow
        op("p1", 1, 0, 0, 16'h0001, 16'h0000);
        op("p2", 1, 0, 0, 16'h0002, 16'h0000);
        op("p3", 1, 0, 0, 16'h0003, 16'h0000);
        chk("p3.cheia", cheia, 0);
        op("p4", 1, 0, 0, 16'h0004, 16'h0000);
        chk("p4.sp", sp, 4);
        chk("p4.cheia", cheia, 1);
        chk("p4.topo", topo, 16'h0004);
        chk("p4.erro_over", erro_over, 0);
`ifdef PILHA_SEGUNDO_EN
        chk("p4.segundo", segundo, 16'h0003);
`endif
        op("p5", 1, 0, 0, 16'h0005, 16'h0000);
        chk("p5.sp", sp, 4);
        chk("p5.topo", topo, 16'h0004);
        chk("p5.erro_over", erro_over, 1);
        chk("p5.erro_under", erro_under, 0);

        // Pop down through every entry, then underflow
        op("pop_a", 0, 1, 0, 16'h0000, 16'h0000);
        chk("pop_a.topo", topo, 16'h0003);
        chk("pop_a.cheia", cheia, 0);
        op("pop_b", 0, 1, 0, 16'h0000, 16'h0000);
        chk("pop_b.topo", topo, 16'h0002);
        chk("pop_b.sp", sp, 2);
        op("pop_c", 0, 1, 0, 16'h0000, 16'h0000);
        chk("pop_c.topo", topo, 16'h0001);
        op("pop_d", 0, 1, 0, 16'h0000, 16'h0000);
        chk("pop_d.topo", topo, 16'h0000);
        chk("pop_d.vazia", vazia, 1);
        chk("pop_d.erro_under", erro_under, 0);
        op("pop_e", 0, 1, 0, 16'h0000, 16'h0000);
        chk("pop_e.erro_under", erro_under, 1);
        chk("pop_e.sp", sp, 0);
        chk("pop_e.erro_over_sticky", erro_over, 1);

        // limpa clears error flags
        limpa = 1'b1; tick(); limpa = 1'b0;
        chk("limpa1.erro_over", erro_over, 0);
        chk("limpa1.erro_under", erro_under, 0);
        chk("limpa1.sp", sp, 0);

        // Push source select and replace-top
        op("q1", 1, 0, 0, 16'h0001, 16'hFFFF);
        op("q2", 1, 0, 1, 16'hFFFF, 16'h0002);
        chk("q2.topo", topo, 16'h0002);
        chk("q2.sp", sp, 2);
        op("rep", 1, 1, 1, 16'hFFFF, 16'h00AA);
        chk("rep.sp", sp, 2);
        chk("rep.topo", topo, 16'h00AA);
        chk("rep.erro_under", erro_under, 0);
`ifdef PILHA_SEGUNDO_EN
        chk("rep.segundo", segundo, 16'h0001);
`endif
        op("rep_pop", 0, 1, 0, 16'h0000, 16'h0000);
        chk("rep_pop.topo", topo, 16'h0001);
        chk("rep_pop.sp", sp, 1);
`ifdef PILHA_SEGUNDO_EN
        chk("rep_pop.segundo", segundo, 16'h0000);
`endif

        // Second strobe while busy is ignored
        push = 1'b1; sel_ula = 1'b0; data_uc = 16'h0007;
        tick();
        data_uc = 16'h0009;
        tick();
        push = 1'b0;
        tick();
        chk("b2b.feito", feito, 1);
        chk("b2b.sp", sp, 2);
        chk("b2b.topo", topo, 16'h0007);
        chk("b2b.erro_over", erro_over, 0);
        tick();
        chk("b2b.ocupado_after", ocupado, 0);
        tick();
        chk("b2b.sp_after", sp, 2);
        chk("b2b.feito_after", feito, 0);

        // limpa aborts an in-flight push
        push = 1'b1; data_uc = 16'h0033;
        tick();
        push = 1'b0; limpa = 1'b1;
        tick();
        limpa = 1'b0;
        chk("abort.sp", sp, 0);
        chk("abort.topo", topo, 0);
        chk("abort.feito", feito, 0);
        chk("abort.ocupado", ocupado, 0);
        chk("abort.erro_over", erro_over, 0);
        tick();
        chk("abort.feito_later", feito, 0);
        chk("abort.sp_later", sp, 0);

        // limpa together with a strobe while idle drops the request
        push = 1'b1; limpa = 1'b1; data_uc = 16'h0044;
        tick();
        push = 1'b0; limpa = 1'b0;
        chk("drop.ocupado", ocupado, 0);
        tick(); tick();
        chk("drop.feito", feito, 0);
        chk("drop.sp", sp, 0);

        // Replace on empty stack underflows without writing
        op("rep_empty", 1, 1, 0, 16'h0055, 16'h0000);
        chk("rep_empty.erro_under", erro_under, 1);
        chk("rep_empty.sp", sp, 0);
        chk("rep_empty.topo", topo, 0);

        // Synchronous reset mid-run
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2.erro_under", erro_under, 0);
        chk("rst2.vazia", vazia, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
